// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of the 16-bit load/store unit: fetch (port 0) vs data (port 1),
// with an RMW bus lock, fetch anti-starvation and single in-flight completion tracking.
module lsu_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        a_rst,

    input  logic        rq0_valid,
    input  logic [15:0] rq0_addr,
    input  logic        rq0_width,
    output logic        rq0_ack,
    output logic        rq0_done,

    input  logic        rq1_valid,
    input  logic [15:0] rq1_addr,
    input  logic [15:0] rq1_data,
    input  logic        rq1_width,
    input  logic        rq1_cmd,
    input  logic        rq1_lock,
    input  logic        rq1_reuse_addr,
    output logic        rq1_ack,
    output logic        rq1_done,

    output logic [15:0] lsu_rq_addr,
    output logic [15:0] lsu_rq_data,
    output logic        lsu_rq_wr_addr,
    output logic        lsu_rq_width,
    output logic        lsu_rq_cmd,
    output logic        lsu_rq_t_id,
    output logic        lsu_rq_start,
    input  logic        lsu_rq_ack,

    input  logic        mem_rdy
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } st_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    st_t        st;
    logic [3:0] starve_cnt;
    logic       inflight;
    logic       inflight_id;
    logic       sel;
    logic       fetch_starved;

    assign fetch_starved = rq0_valid && (starve_cnt == STARVE_LIM);

    // Locked bus belongs to port 1; otherwise data wins unless fetch has waited too long.
    always_comb begin
        sel = 1'b0;
        if (st == LOCKED) begin
            sel = 1'b1;
        end else if (fetch_starved) begin
            sel = 1'b0;
        end else if (rq1_valid) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
    end

    assign lsu_rq_start   = sel ? rq1_valid : rq0_valid;
    assign lsu_rq_addr    = sel ? rq1_addr  : rq0_addr;
    assign lsu_rq_data    = sel ? rq1_data  : 16'h0000;
    assign lsu_rq_width   = sel ? rq1_width : rq0_width;
    assign lsu_rq_cmd     = sel & rq1_cmd;
    assign lsu_rq_t_id    = sel;
    assign lsu_rq_wr_addr = ~(sel & rq1_reuse_addr);

    assign rq0_ack = lsu_rq_ack & lsu_rq_start & ~sel;
    assign rq1_ack = lsu_rq_ack & lsu_rq_start &  sel;

    // Completion uses the tracker state before this cycle's update.
    assign rq0_done = inflight & mem_rdy & ~inflight_id;
    assign rq1_done = inflight & mem_rdy &  inflight_id;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            st <= UNLOCKED;
        end else begin
            case (st)
                UNLOCKED: if (rq1_ack &&  rq1_lock) st <= LOCKED;
                LOCKED:   if (rq1_ack && !rq1_lock) st <= UNLOCKED;
                default:  st <= UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            starve_cnt <= 4'd0;
        end else if (rq0_ack) begin
            starve_cnt <= 4'd0;
        end else if (st == UNLOCKED && rq1_ack && rq0_valid && starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // A new acceptance overrides a completion landing in the same cycle.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            inflight    <= 1'b0;
            inflight_id <= 1'b0;
        end else if (lsu_rq_ack) begin
            inflight    <= 1'b1;
            inflight_id <= sel;
        end else if (inflight && mem_rdy) begin
            inflight    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: reset, single fetch, starvation pattern, locked RMW,
// back-to-back completion, spurious mem_rdy and asynchronous reset mid-transaction.
module tb_lsu_arbiter;

    logic        clk;
    logic        a_rst;
    logic        rq0_valid;
    logic [15:0] rq0_addr;
    logic        rq0_width;
    logic        rq0_ack;
    logic        rq0_done;
    logic        rq1_valid;
    logic [15:0] rq1_addr;
    logic [15:0] rq1_data;
    logic        rq1_width;
    logic        rq1_cmd;
    logic        rq1_lock;
    logic        rq1_reuse_addr;
    logic        rq1_ack;
    logic        rq1_done;
    logic [15:0] lsu_rq_addr;
    logic [15:0] lsu_rq_data;
    logic        lsu_rq_wr_addr;
    logic        lsu_rq_width;
    logic        lsu_rq_cmd;
    logic        lsu_rq_t_id;
    logic        lsu_rq_start;
    logic        lsu_rq_ack;
    logic        mem_rdy;

    int n_checks;
    int n_errors;

    lsu_arbiter #(.STARVE_MAX(3)) dut (
        .clk            (clk),
        .a_rst          (a_rst),
        .rq0_valid      (rq0_valid),
        .rq0_addr       (rq0_addr),
        .rq0_width      (rq0_width),
        .rq0_ack        (rq0_ack),
        .rq0_done       (rq0_done),
        .rq1_valid      (rq1_valid),
        .rq1_addr       (rq1_addr),
        .rq1_data       (rq1_data),
        .rq1_width      (rq1_width),
        .rq1_cmd        (rq1_cmd),
        .rq1_lock       (rq1_lock),
        .rq1_reuse_addr (rq1_reuse_addr),
        .rq1_ack        (rq1_ack),
        .rq1_done       (rq1_done),
        .lsu_rq_addr    (lsu_rq_addr),
        .lsu_rq_data    (lsu_rq_data),
        .lsu_rq_wr_addr (lsu_rq_wr_addr),
        .lsu_rq_width   (lsu_rq_width),
        .lsu_rq_cmd     (lsu_rq_cmd),
        .lsu_rq_t_id    (lsu_rq_t_id),
        .lsu_rq_start   (lsu_rq_start),
        .lsu_rq_ack     (lsu_rq_ack),
        .mem_rdy        (mem_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rq0_valid      = 1'b0;
        rq0_addr       = 16'h0000;
        rq0_width      = 1'b0;
        rq1_valid      = 1'b0;
        rq1_addr       = 16'h0000;
        rq1_data       = 16'h0000;
        rq1_width      = 1'b0;
        rq1_cmd        = 1'b0;
        rq1_lock       = 1'b0;
        rq1_reuse_addr = 1'b0;
        lsu_rq_ack     = 1'b0;
        mem_rdy        = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        a_rst = 1'b1;
        #2;
        a_rst = 1'b0;
    endtask

    logic exp_ack1 [8];
    int   exp_cnt  [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        a_rst = 1'b1;
        idle_inputs();
        exp_ack1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_cnt  = '{0, 1, 2, 3, 0, 1, 2, 3};
        #12;
        a_rst = 1'b0;

        // Reset state
        #1;
        check_eq("rst_start", 32'(lsu_rq_start), 32'd0);
        check_eq("rst_acks", {30'd0, rq1_ack, rq0_ack}, 32'd0);
        check_eq("rst_dones", {30'd0, rq1_done, rq0_done}, 32'd0);
        check_eq("rst_st", 32'(dut.st), 32'd0);
        check_eq("rst_starve", 32'(dut.starve_cnt), 32'd0);
        check_eq("rst_inflight", 32'(dut.inflight), 32'd0);

        // Single fetch at 0x1000, completion two cycles later
        tick();
        rq0_valid = 1'b1; rq0_addr = 16'h1000; rq0_width = 1'b1; lsu_rq_ack = 1'b1;
        #1;
        check_eq("fetch_ack0", 32'(rq0_ack), 32'd1);
        check_eq("fetch_ack1", 32'(rq1_ack), 32'd0);
        check_eq("fetch_tid", 32'(lsu_rq_t_id), 32'd0);
        check_eq("fetch_cmd", 32'(lsu_rq_cmd), 32'd0);
        check_eq("fetch_addr", 32'(lsu_rq_addr), 32'h1000);
        check_eq("fetch_data", 32'(lsu_rq_data), 32'h0);
        check_eq("fetch_width", 32'(lsu_rq_width), 32'd1);
        check_eq("fetch_wr_addr", 32'(lsu_rq_wr_addr), 32'd1);
        tick();
        rq0_valid = 1'b0; lsu_rq_ack = 1'b0;
        #1;
        check_eq("fetch_wait_done0", 32'(rq0_done), 32'd0);
        tick();
        mem_rdy = 1'b1;
        #1;
        check_eq("fetch_done0", 32'(rq0_done), 32'd1);
        check_eq("fetch_done1", 32'(rq1_done), 32'd0);
        tick();
        #1;
        check_eq("fetch_done_once", 32'(rq0_done), 32'd0);
        check_eq("fetch_inflight_clr", 32'(dut.inflight), 32'd0);

        // Spurious mem_rdy with nothing in flight
        tick();
        mem_rdy = 1'b1;
        #1;
        check_eq("spur_dones", {30'd0, rq1_done, rq0_done}, 32'd0);
        tick();
        mem_rdy = 1'b0;
        #1;
        check_eq("spur_inflight", 32'(dut.inflight), 32'd0);
        check_eq("spur_st", 32'(dut.st), 32'd0);
        check_eq("spur_starve", 32'(dut.starve_cnt), 32'd0);

        // Starvation guard: both ports hammering, LSU always ready
        do_reset();
        tick();
        rq0_valid = 1'b1; rq0_addr = 16'h1100;
        rq1_valid = 1'b1; rq1_addr = 16'h3000;
        lsu_rq_ack = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("starve_cnt_%0d", i), 32'(dut.starve_cnt), 32'(exp_cnt[i]));
            check_eq($sformatf("starve_ack1_%0d", i), 32'(rq1_ack), 32'(exp_ack1[i]));
            check_eq($sformatf("starve_ack0_%0d", i), 32'(rq0_ack), 32'(!exp_ack1[i]));
            tick();
        end
        check_eq("starve_cnt_after", 32'(dut.starve_cnt), 32'd0);

        // Locked RMW while fetch keeps asking; counter reaches the limit on the lock access
        do_reset();
        tick();
        rq0_valid = 1'b1; rq0_addr = 16'h1200;
        rq1_valid = 1'b1; rq1_addr = 16'h4000;
        lsu_rq_ack = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rmw_pre_cnt", 32'(dut.starve_cnt), 32'd2);
        rq1_addr = 16'h2001; rq1_cmd = 1'b0; rq1_lock = 1'b1; rq1_reuse_addr = 1'b0;
        #1;
        check_eq("rmw_a1_ack1", 32'(rq1_ack), 32'd1);
        check_eq("rmw_a1_wr_addr", 32'(lsu_rq_wr_addr), 32'd1);
        tick();
        rq1_valid = 1'b0;
        #1;
        check_eq("rmw_locked", 32'(dut.st), 32'd1);
        check_eq("rmw_cnt_max", 32'(dut.starve_cnt), 32'd3);
        check_eq("rmw_gap_ack0", 32'(rq0_ack), 32'd0);
        check_eq("rmw_gap_start", 32'(lsu_rq_start), 32'd0);
        tick();
        rq1_valid = 1'b1; rq1_cmd = 1'b1; rq1_data = 16'hBEEF; rq1_lock = 1'b0; rq1_reuse_addr = 1'b1;
        #1;
        check_eq("rmw_a2_ack1", 32'(rq1_ack), 32'd1);
        check_eq("rmw_a2_ack0", 32'(rq0_ack), 32'd0);
        check_eq("rmw_a2_wr_addr", 32'(lsu_rq_wr_addr), 32'd0);
        check_eq("rmw_a2_cmd", 32'(lsu_rq_cmd), 32'd1);
        check_eq("rmw_a2_data", 32'(lsu_rq_data), 32'hBEEF);
        check_eq("rmw_a2_addr", 32'(lsu_rq_addr), 32'h2001);
        tick();
        rq1_valid = 1'b0; rq1_cmd = 1'b0; rq1_reuse_addr = 1'b0;
        #1;
        check_eq("rmw_unlocked", 32'(dut.st), 32'd0);
        check_eq("rmw_fetch_ack", 32'(rq0_ack), 32'd1);
        tick();
        #1;
        check_eq("rmw_cnt_clear", 32'(dut.starve_cnt), 32'd0);

        // Back-to-back: data accepted in the cycle a fetch completes
        do_reset();
        tick();
        rq0_valid = 1'b1; rq0_addr = 16'h1300; lsu_rq_ack = 1'b1;
        tick();
        rq0_valid = 1'b0;
        rq1_valid = 1'b1; rq1_addr = 16'h5000; rq1_cmd = 1'b1; rq1_data = 16'h1234;
        mem_rdy = 1'b1;
        #1;
        check_eq("b2b_done0", 32'(rq0_done), 32'd1);
        check_eq("b2b_ack1", 32'(rq1_ack), 32'd1);
        check_eq("b2b_done1_early", 32'(rq1_done), 32'd0);
        tick();
        rq1_valid = 1'b0; rq1_cmd = 1'b0; lsu_rq_ack = 1'b0;
        #1;
        check_eq("b2b_done1", 32'(rq1_done), 32'd1);
        check_eq("b2b_done0_late", 32'(rq0_done), 32'd0);
        tick();
        mem_rdy = 1'b0;

        // Async reset while locked with a transaction in flight
        do_reset();
        tick();
        rq1_valid = 1'b1; rq1_addr = 16'h6000; rq1_lock = 1'b1; lsu_rq_ack = 1'b1;
        tick();
        rq1_valid = 1'b0; rq1_lock = 1'b0; lsu_rq_ack = 1'b0;
        #1;
        check_eq("arst_pre_locked", 32'(dut.st), 32'd1);
        check_eq("arst_pre_inflight", 32'(dut.inflight), 32'd1);
        mem_rdy = 1'b1;
        a_rst = 1'b1;
        #1;
        check_eq("arst_st", 32'(dut.st), 32'd0);
        check_eq("arst_inflight", 32'(dut.inflight), 32'd0);
        check_eq("arst_starve", 32'(dut.starve_cnt), 32'd0);
        check_eq("arst_dones", {30'd0, rq1_done, rq0_done}, 32'd0);
        check_eq("arst_start", 32'(lsu_rq_start), 32'd0);
        #1;
        a_rst = 1'b0;
        mem_rdy = 1'b0;
        rq0_valid = 1'b1; rq0_addr = 16'h1400; lsu_rq_ack = 1'b1;
        #1;
        check_eq("arst_fetch_ack", 32'(rq0_ack), 32'd1);
        tick();
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
